// File: rtl/router_pkg.sv
// Shared types, header field layout and port helpers for the 1x3 router intake controller.
package router_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned ADDR_W    = 2;

    localparam int unsigned LEN_MSB  = 7;
    localparam int unsigned LEN_LSB  = 2;
    localparam int unsigned ADDR_MSB = 1;
    localparam int unsigned ADDR_LSB = 0;

    localparam int unsigned LEN_W = LEN_MSB - LEN_LSB + 1;
    // Remaining count covers L payload bytes plus the parity byte.
    localparam int unsigned CNT_W = LEN_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWaitEmpty,
        StLfd,
        StHdr,
        StLoad,
        StHold,
        StCheck,
        StDrop
    } state_e;

    // Invalid address yields an all-zero select, so it never touches a FIFO.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] dest);
        logic [NUM_PORTS-1:0] sel;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel[p] = (dest == p[ADDR_W-1:0]);
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity accumulator for one packet: clear, fold a byte, compare against
// the received parity byte.
module router_parity_acc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              fold,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] cmp,
    output logic              mismatch
);

    logic [DATA_W-1:0] acc_q, acc_d;

    // clear and fold together load din directly (used for the header byte).
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end
        if (fold) begin
            acc_d = acc_d ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign mismatch = (acc_q != cmp);

endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet-intake controller for the 1x3 router: header decode, FIFO write control with
// back-pressure, and optional parity check (enabled by defining ROUTER_PARITY_CHECK_EN).
module router_pkt_ctrl
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [DATA_W-1:0]    data_out,
    output logic                 err,
    output logic                 pkt_done
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]    dest_q;
    logic [ADDR_W-1:0]    hdr_dest;
    logic [LEN_W-1:0]     hdr_len;
    logic [DATA_W-1:0]    hdr_q;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [NUM_PORTS-1:0] write_enb_q, write_enb_d;
    logic [NUM_PORTS-1:0] dest_sel;
    logic                 lfd_q, lfd_d;
    logic                 dest_full, dest_empty, dest_abort, dest_we;
    logic                 can_take, accept, last_byte;

    assign hdr_dest = data_in[ADDR_MSB:ADDR_LSB];
    assign hdr_len  = data_in[LEN_MSB:LEN_LSB];

    assign dest_sel   = port_onehot(dest_q);
    assign dest_full  = |(fifo_full & dest_sel);
    assign dest_empty = |(fifo_empty & dest_sel);
    assign dest_abort = |(soft_rst & dest_sel);
    assign dest_we    = |(write_enb_q & dest_sel);
    assign last_byte  = (remaining_q == CNT_W'(1));

    always_comb begin
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StLoad:  busy = dest_we && dest_full;
            StDrop:  busy = 1'b0;
            default: busy = 1'b1;
        endcase
    end

    // Once the count is exhausted, LOAD only waits for the parity write to commit.
    assign can_take = (state_q == StIdle) ||
                      (((state_q == StLoad) || (state_q == StDrop)) && (remaining_q != '0));
    assign accept   = pkt_valid && !busy && can_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hdr_dest == ADDR_INVALID) begin
                        state_d = StDrop;
                    end else if (|(fifo_empty & port_onehot(hdr_dest))) begin
                        state_d = StLfd;
                    end else begin
                        state_d = StWaitEmpty;
                    end
                end
            end
            StWaitEmpty: if (dest_empty) state_d = StLfd;
            StLfd:       state_d = StHdr;
            StHdr:       state_d = dest_full ? StHold : StLoad;
            StLoad: begin
                if (dest_we) begin
                    if (dest_full) begin
                        state_d = StHold;
                    end else if (remaining_q == '0) begin
                        state_d = StCheck;
                    end
                end
            end
            StHold:  if (!dest_full) state_d = (remaining_q == '0) ? StCheck : StLoad;
            StCheck: state_d = StIdle;
            StDrop:  if (accept && last_byte) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if ((state_q != StIdle) && dest_abort) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        write_enb_d = '0;
        data_out_d  = data_out_q;
        lfd_d       = (state_d == StLfd);
        remaining_d = remaining_q;
        if (state_d == StHdr) begin
            write_enb_d = dest_sel;
            data_out_d  = hdr_q;
        end else if (state_d == StHold) begin
            write_enb_d = write_enb_q;
        end
        if ((state_q == StLoad) && accept && !dest_abort) begin
            write_enb_d = dest_sel;
            data_out_d  = data_in;
        end
        if (accept) begin
            remaining_d = (state_q == StIdle) ? CNT_W'(hdr_len) + CNT_W'(1)
                                              : remaining_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q       <= '0;
            dest_q      <= '0;
            remaining_q <= '0;
            write_enb_q <= '0;
            data_out_q  <= '0;
            lfd_q       <= 1'b0;
        end else begin
            if ((state_q == StIdle) && accept) begin
                hdr_q  <= data_in;
                dest_q <= hdr_dest;
            end
            remaining_q <= remaining_d;
            write_enb_q <= write_enb_d;
            data_out_q  <= data_out_d;
            lfd_q       <= lfd_d;
        end
    end

    assign write_enb = write_enb_q;
    assign data_out  = data_out_q;
    assign lfd_state = lfd_q;
    assign pkt_done  = (state_q == StCheck);

`ifdef ROUTER_PARITY_CHECK_EN
    logic par_clear, par_fold, par_mismatch;

    // Header seeds the accumulator; payload bytes fold in; the parity byte does not.
    assign par_clear = accept && (state_q == StIdle);
    assign par_fold  = accept && ((state_q == StIdle) || ((state_q == StLoad) && !last_byte));

    router_parity_acc u_parity_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (par_clear),
        .fold     (par_fold),
        .din      (data_in),
        .cmp      (data_out_q),
        .mismatch (par_mismatch)
    );

    assign err = (state_q == StCheck) && par_mismatch && !dest_abort;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed self-checking bench for router_pkt_ctrl; expected err depends on
// ROUTER_PARITY_CHECK_EN.
module tb_router_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_rst = 3'b000;
    logic       busy;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] data_out;
    logic       err;
    logic       pkt_done;

    int checks = 0;
    int errors = 0;

`ifdef ROUTER_PARITY_CHECK_EN
    localparam int PAR_ERR = 1;
`else
    localparam int PAR_ERR = 0;
`endif

    // Committed writes as {port, data}, plus pulse counters; tasks compare deltas.
    logic [9:0] wlog[$];
    int lfd_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int we_cnt = 0;

    router_pkt_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .soft_rst   (soft_rst),
        .busy       (busy),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_out   (data_out),
        .err        (err),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                if (write_enb[p] && !fifo_full[p]) wlog.push_back({p[1:0], data_out});
            end
            if (lfd_state) lfd_cnt++;
            if (pkt_done) done_cnt++;
            if (err) err_cnt++;
            if (write_enb != 3'b000) we_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        pkt_valid = 1'b1;
        data_in = b;
        for (int n = 0; n < 50 && !taken; n++) begin
            @(negedge clk);
            if (!busy) taken = 1'b1;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL accept_timeout byte %h: got not accepted in 50 cycles, want accepted", b);
        end
    endtask

    task automatic wait_done(input int base);
        for (int n = 0; n < 40 && done_cnt == base; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (write_enb !== 3'b000) begin errors++; $display("FAIL reset_we got %b want 000", write_enb); end
        checks++; if (lfd_state !== 1'b0) begin errors++; $display("FAIL reset_lfd got %b want 0", lfd_state); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", pkt_done); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_packet(input logic [7:0] par, input int exp_err);
        logic [9:0] exp [5] = '{10'h10D, 10'h111, 10'h122, 10'h133, {2'd1, par}};
        int lb = wlog.size();
        int db = done_cnt;
        int eb = err_cnt;
        int fb = lfd_cnt;
        time t0;
        send_byte(8'h0D);
        pkt_valid = 1'b1;
        data_in = 8'h11;
        @(negedge clk);
        checks++;
        if (lfd_state !== 1'b1 || write_enb !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lfd_cycle got lfd=%b we=%b busy=%b want lfd=1 we=000 busy=1",
                     lfd_state, write_enb, busy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (lfd_state !== 1'b0 || write_enb !== 3'b010 || data_out !== 8'h0D) begin
            errors++;
            $display("FAIL hdr_cycle got lfd=%b we=%b data=%h want lfd=0 we=010 data=0d",
                     lfd_state, write_enb, data_out);
        end
        @(posedge clk);
        #1;
        t0 = $time;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(par);
        checks++;
        if ($time - t0 !== 40) begin
            errors++;
            $display("FAIL throughput got %0t want 40 for 4 bytes", $time - t0);
        end
        wait_done(db);
        checks++;
        if (wlog.size() - lb !== 5) begin
            errors++;
            $display("FAIL pkt_write_count got %0d want 5", wlog.size() - lb);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wlog[lb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL pkt_write[%0d] got %h want %h", i, wlog[lb+i], exp[i]);
                end
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL pkt_done_count got %0d want 1", done_cnt - db); end
        checks++; if (err_cnt - eb !== exp_err) begin errors++; $display("FAIL pkt_err_count got %0d want %0d", err_cnt - eb, exp_err); end
        checks++; if (lfd_cnt - fb !== 1) begin errors++; $display("FAIL pkt_lfd_count got %0d want 1", lfd_cnt - fb); end
    endtask

    task automatic test_wait_empty();
        logic [9:0] exp [3] = '{10'h206, 10'h2AA, 10'h2AC};
        int lb = wlog.size();
        int db = done_cnt;
        int eb = err_cnt;
        int fb = lfd_cnt;
        int wb = we_cnt;
        fifo_empty = 3'b011;
        send_byte(8'h06);
        pkt_valid = 1'b1;
        data_in = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b want 1", busy); end
        checks++;
        if (we_cnt - wb !== 0 || lfd_cnt - fb !== 0) begin
            errors++;
            $display("FAIL wait_quiet got we_cycles=%0d lfd_cycles=%0d want 0 0", we_cnt - wb, lfd_cnt - fb);
        end
        @(posedge clk);
        #1 fifo_empty = 3'b111;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (lfd_state !== 1'b1) begin errors++; $display("FAIL wait_lfd got %b want 1", lfd_state); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (write_enb !== 3'b100 || data_out !== 8'h06) begin
            errors++;
            $display("FAIL wait_hdr got we=%b data=%h want we=100 data=06", write_enb, data_out);
        end
        @(posedge clk);
        #1;
        send_byte(8'hAA);
        send_byte(8'hAC);
        wait_done(db);
        checks++;
        if (wlog.size() - lb !== 3) begin
            errors++;
            $display("FAIL wait_write_count got %0d want 3", wlog.size() - lb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wlog[lb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL wait_write[%0d] got %h want %h", i, wlog[lb+i], exp[i]);
                end
            end
        end
        checks++; if (err_cnt - eb !== 0) begin errors++; $display("FAIL wait_err got %0d want 0", err_cnt - eb); end
    endtask

    task automatic test_fifo_full();
        logic [9:0] exp [6] = '{10'h010, 10'h001, 10'h002, 10'h003, 10'h004, 10'h014};
        int lb = wlog.size();
        int db = done_cnt;
        int eb = err_cnt;
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h02);
        fifo_full = 3'b001;
        pkt_valid = 1'b1;
        data_in = 8'h03;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || write_enb !== 3'b001 || data_out !== 8'h02) begin
            errors++;
            $display("FAIL full_first got busy=%b we=%b data=%h want busy=1 we=001 data=02",
                     busy, write_enb, data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || write_enb !== 3'b001 || data_out !== 8'h02) begin
            errors++;
            $display("FAIL full_hold got busy=%b we=%b data=%h want busy=1 we=001 data=02",
                     busy, write_enb, data_out);
        end
        @(posedge clk);
        #1 fifo_full = 3'b000;
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h14);
        wait_done(db);
        checks++;
        if (wlog.size() - lb !== 6) begin
            errors++;
            $display("FAIL full_write_count got %0d want 6", wlog.size() - lb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[lb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL full_write[%0d] got %h want %h", i, wlog[lb+i], exp[i]);
                end
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL full_done got %0d want 1", done_cnt - db); end
        checks++; if (err_cnt - eb !== 0) begin errors++; $display("FAIL full_err got %0d want 0", err_cnt - eb); end
    endtask

    task automatic test_soft_rst();
        logic [9:0] exp [5] = '{10'h10D, 10'h111, 10'h122, 10'h133, 10'h10D};
        int db = done_cnt;
        int eb = err_cnt;
        int lb;
        send_byte(8'h0D);
        send_byte(8'h11);
        soft_rst = 3'b010;
        @(posedge clk);
        #1 soft_rst = 3'b000;
        @(negedge clk);
        checks++;
        if (write_enb !== 3'b000 || lfd_state !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL srst_idle got we=%b lfd=%b busy=%b want 000 0 0", write_enb, lfd_state, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - db !== 0 || err_cnt - eb !== 0) begin
            errors++;
            $display("FAIL srst_pulses got done=%0d err=%0d want 0 0", done_cnt - db, err_cnt - eb);
        end
        // Follow-up packet, with an abort on an unrelated FIFO mid-payload.
        lb = wlog.size();
        db = done_cnt;
        send_byte(8'h0D);
        send_byte(8'h11);
        soft_rst = 3'b001;
        send_byte(8'h22);
        soft_rst = 3'b000;
        send_byte(8'h33);
        send_byte(8'h0D);
        wait_done(db);
        checks++;
        if (wlog.size() - lb !== 5) begin
            errors++;
            $display("FAIL srst_next_count got %0d want 5", wlog.size() - lb);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wlog[lb+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL srst_next_write[%0d] got %h want %h", i, wlog[lb+i], exp[i]);
                end
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL srst_next_done got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_drop_and_zero_len();
        int lb = wlog.size();
        int db = done_cnt;
        int eb = err_cnt;
        int fb = lfd_cnt;
        int wb = we_cnt;
        send_byte(8'h0B);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_cnt - wb !== 0 || wlog.size() - lb !== 0) begin
            errors++;
            $display("FAIL drop_writes got we_cycles=%0d writes=%0d want 0 0", we_cnt - wb, wlog.size() - lb);
        end
        checks++;
        if (done_cnt - db !== 0 || err_cnt - eb !== 0 || lfd_cnt - fb !== 0) begin
            errors++;
            $display("FAIL drop_pulses got done=%0d err=%0d lfd=%0d want 0 0 0",
                     done_cnt - db, err_cnt - eb, lfd_cnt - fb);
        end
        // L=0 packet: parity equals header.
        send_byte(8'h01);
        send_byte(8'h01);
        wait_done(db);
        checks++;
        if (wlog.size() - lb !== 2) begin
            errors++;
            $display("FAIL zlen_write_count got %0d want 2", wlog.size() - lb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wlog[lb+i] !== 10'h101) begin
                    errors++;
                    $display("FAIL zlen_write[%0d] got %h want 101", i, wlog[lb+i]);
                end
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL zlen_done got %0d want 1", done_cnt - db); end
        checks++; if (err_cnt - eb !== 0) begin errors++; $display("FAIL zlen_err got %0d want 0", err_cnt - eb); end
    endtask

    task automatic test_async_reset();
        send_byte(8'h0D);
        send_byte(8'h11);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (write_enb !== 3'b000 || lfd_state !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL arst_regs got we=%b lfd=%b data=%h want 000 0 00", write_enb, lfd_state, data_out);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL arst_comb got busy=%b err=%b done=%b want 0 0 0", busy, err, pkt_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_packet(8'h0D, 0);
        test_packet(8'h00, PAR_ERR);
        test_wait_empty();
        test_fifo_full();
        test_soft_rst();
        test_drop_and_zero_len();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
